if_id_stage: RTL and testbench
==============================

IF_ID_STAGE -- requirements
Module: if_id_stage

Interface
REQ-001 The block SHALL take parameter RESET_PC, default 32'h0000_0000: PC value loaded on reset.
REQ-002 The block SHALL take parameter NOP_INSTR, default 32'h0000_0013 (addi x0,x0,0): instruction word held in a bubble.
REQ-003 The block SHALL have port clk, input, 1, the single clock; all state updates on its rising edge.
REQ-004 The block SHALL have port rst, input, 1, asynchronous active-high reset.
REQ-005 The block SHALL have port stall, input, 1, hazard-unit freeze request for the IF and ID stages.
REQ-006 The block SHALL have port branch_taken, input, 1, EX-stage redirect request.
REQ-007 The block SHALL have port branch_target, input, 32, redirect address.
REQ-008 The block SHALL have port imem_addr, output, 32, instruction-memory address equal to the current PC.
REQ-009 The block SHALL have port imem_rdata, input, 32, instruction word for imem_addr, combinational in the same cycle.
REQ-010 The block SHALL have port imem_ready, input, 1, imem_rdata valid this cycle (0 = wait state).
REQ-011 The block SHALL have port IF_ID_pc, output, 32, PC of the instruction held in IF/ID.
REQ-012 The block SHALL have port IF_ID_instr, output, 32, instruction held in IF/ID.
REQ-013 The block SHALL have port IF_ID_valid, output, 1, IF/ID holds a real instruction.
REQ-014 The block SHALL have ports IF_ID_Rs1 and IF_ID_Rs2, output, 5 each, source fields driven to the hazard unit.
REQ-015 The block SHALL have port fetch_count, output, 32, count of instructions accepted into IF/ID.

Function
REQ-016 The block SHALL drive imem_addr combinationally from the PC register.
REQ-017 The block SHALL apply the following per-cycle priority: branch_taken, then stall, then normal fetch.
REQ-018 On branch_taken=1, the block SHALL load PC with {branch_target[31:2],2'b00} and load IF/ID with a bubble, regardless of stall and imem_ready.
REQ-019 A bubble SHALL be: IF_ID_valid=0, IF_ID_instr=NOP_INSTR, IF_ID_pc unchanged.
REQ-020 On stall=1 without branch_taken, PC, IF/ID contents and fetch_count SHALL all hold.
REQ-021 On a normal cycle with imem_ready=1, the block SHALL set IF/ID to {PC, imem_rdata, valid=1}, set PC to PC+4 (modulo 2^32, 32'hFFFF_FFFC wraps to 0), and increment fetch_count.
REQ-022 On a normal cycle with imem_ready=0, PC SHALL hold and IF/ID SHALL take a bubble.
REQ-023 IF_ID_Rs1 SHALL equal IF_ID_instr[19:15] and IF_ID_Rs2 SHALL equal IF_ID_instr[24:20] when IF_ID_valid=1; both SHALL be 5'd0 otherwise.
REQ-024 fetch_count SHALL wrap from 32'hFFFF_FFFF to 0 without flagging.
REQ-025 Fetch-to-IF/ID latency SHALL be one cycle; there SHALL be no internal buffering beyond the IF/ID register.

Reset
REQ-026 While rst=1, the block SHALL hold PC=RESET_PC, IF_ID_pc=0, IF_ID_instr=NOP_INSTR, IF_ID_valid=0, IF_ID_Rs1=IF_ID_Rs2=0, fetch_count=0.
REQ-027 Reset assertion mid-stall or mid-wait-state SHALL discard all in-flight state immediately, without waiting for a clock edge.
REQ-028 The first fetch SHALL occur on the first rising edge after rst deasserts, from RESET_PC.

Structure
REQ-029 NOP_INSTR default, RESET_PC default, XLEN=32 and the register-index width 5 SHALL live in a shared package riscv_pkg.
REQ-030 The PC register and next-PC mux SHALL be a sub-module pc_gen; the IF/ID register, Rs decode and counter SHALL stay in if_id_stage.

Verification
REQ-031 Release rst with imem_ready=1 and rdata=32'h00A00093 -> next cycle IF_ID_pc=0, instr=32'h00A00093, valid=1, Rs1=0; PC=4.
REQ-032 Assert stall for 2 cycles at PC=8 -> imem_addr stays 8, IF/ID unchanged, fetch_count unchanged; fetch resumes at 8 afterwards.
REQ-033 Assert stall and branch_taken together with target 32'h0000_0103 -> PC=32'h0000_0100, IF_ID_valid=0, IF_ID_instr=32'h00000013.
REQ-034 Drive imem_ready=0 for 3 cycles at PC=12 -> three bubbles with Rs1=Rs2=0; then ready=1 -> IF_ID_pc=12.
REQ-035 Branch to 32'hFFFF_FFFC, then one normal fetch -> IF_ID_pc=32'hFFFF_FFFC and PC=0.
REQ-036 Pulse rst during a stall at PC=20 -> outputs immediately at reset values; PC=RESET_PC.

Source files
------------

// File: rtl/riscv_pkg.sv
// Shared RV32 fetch-path constants: datapath width, register-index width and reset defaults.
package riscv_pkg;
  localparam int XLEN  = 32;
  localparam int REG_W = 5;

  localparam logic [XLEN-1:0] RESET_PC_DEFAULT  = 32'h0000_0000;
  localparam logic [XLEN-1:0] NOP_INSTR_DEFAULT = 32'h0000_0013;  // addi x0,x0,0

  // Fetch addresses are always word aligned; redirect targets are forced onto that grid.
  localparam logic [XLEN-1:0] PC_ALIGN_MASK = 32'hFFFF_FFFC;
  localparam logic [XLEN-1:0] PC_STEP       = 32'd4;
endpackage

// File: rtl/pc_gen.sv
// PC register and next-PC select: redirect beats advance, otherwise hold.
// One-cycle update; the caller folds stall and wait states into advance_i.
module pc_gen
  import riscv_pkg::*;
#(
  parameter logic [XLEN-1:0] RESET_PC = RESET_PC_DEFAULT
) (
  input  logic            clk,
  input  logic            rst,
  input  logic            branch_taken_i,
  input  logic [XLEN-1:0] branch_target_i,
  input  logic            advance_i,
  output logic [XLEN-1:0] pc_o
);

  logic [XLEN-1:0] pc_q;
  logic [XLEN-1:0] pc_d;

  always_comb begin
    pc_d = pc_q;
    if (branch_taken_i) begin
      pc_d = branch_target_i & PC_ALIGN_MASK;
    end else if (advance_i) begin
      pc_d = pc_q + PC_STEP;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      pc_q <= RESET_PC;
    end else begin
      pc_q <= pc_d;
    end
  end

  assign pc_o = pc_q;

endmodule

// File: rtl/if_id_stage.sv
// IF stage plus IF/ID pipeline register: one-cycle fetch latency, no extra buffering.
// Stall freezes everything; imem wait states and redirects insert bubbles.
module if_id_stage
  import riscv_pkg::*;
#(
  parameter logic [XLEN-1:0] RESET_PC  = RESET_PC_DEFAULT,
  parameter logic [XLEN-1:0] NOP_INSTR = NOP_INSTR_DEFAULT
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             stall,
  input  logic             branch_taken,
  input  logic [XLEN-1:0]  branch_target,
  output logic [XLEN-1:0]  imem_addr,
  input  logic [XLEN-1:0]  imem_rdata,
  input  logic             imem_ready,
  output logic [XLEN-1:0]  IF_ID_pc,
  output logic [XLEN-1:0]  IF_ID_instr,
  output logic             IF_ID_valid,
  output logic [REG_W-1:0] IF_ID_Rs1,
  output logic [REG_W-1:0] IF_ID_Rs2,
  output logic [XLEN-1:0]  fetch_count
);

  logic [XLEN-1:0] pc;
  logic            fetch_fire;

  logic [XLEN-1:0] ifid_pc_q,    ifid_pc_d;
  logic [XLEN-1:0] ifid_instr_q, ifid_instr_d;
  logic            ifid_valid_q, ifid_valid_d;
  logic [XLEN-1:0] count_q,      count_d;

  // A fetch only completes when nothing outranks it and memory has the word.
  assign fetch_fire = !branch_taken && !stall && imem_ready;

  pc_gen #(
    .RESET_PC(RESET_PC)
  ) u_pc_gen (
    .clk            (clk),
    .rst            (rst),
    .branch_taken_i (branch_taken),
    .branch_target_i(branch_target),
    .advance_i      (fetch_fire),
    .pc_o           (pc)
  );

  assign imem_addr = pc;

  always_comb begin
    ifid_pc_d    = ifid_pc_q;
    ifid_instr_d = ifid_instr_q;
    ifid_valid_d = ifid_valid_q;
    count_d      = count_q;
    if (branch_taken || (!stall && !imem_ready)) begin
      // Bubble keeps the old PC so debug views still show where the slot came from.
      ifid_instr_d = NOP_INSTR;
      ifid_valid_d = 1'b0;
    end else if (fetch_fire) begin
      ifid_pc_d    = pc;
      ifid_instr_d = imem_rdata;
      ifid_valid_d = 1'b1;
      count_d      = count_q + 32'd1;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      ifid_pc_q    <= '0;
      ifid_instr_q <= NOP_INSTR;
      ifid_valid_q <= 1'b0;
      count_q      <= '0;
    end else begin
      ifid_pc_q    <= ifid_pc_d;
      ifid_instr_q <= ifid_instr_d;
      ifid_valid_q <= ifid_valid_d;
      count_q      <= count_d;
    end
  end

  assign IF_ID_pc    = ifid_pc_q;
  assign IF_ID_instr = ifid_instr_q;
  assign IF_ID_valid = ifid_valid_q;
  assign fetch_count = count_q;

  // Bubbles present x0 sources so the hazard unit never matches on stale fields.
  assign IF_ID_Rs1 = ifid_valid_q ? ifid_instr_q[19:15] : '0;
  assign IF_ID_Rs2 = ifid_valid_q ? ifid_instr_q[24:20] : '0;

endmodule

// File: tb/tb_if_id_stage.sv
// Directed table-driven bench for if_id_stage plus hand sequences for async reset.
module tb_if_id_stage;

  logic        clk = 1'b0;
  logic        rst;
  logic        stall;
  logic        branch_taken;
  logic [31:0] branch_target;
  logic [31:0] imem_addr;
  logic [31:0] imem_rdata;
  logic        imem_ready;
  logic [31:0] IF_ID_pc;
  logic [31:0] IF_ID_instr;
  logic        IF_ID_valid;
  logic [4:0]  IF_ID_Rs1;
  logic [4:0]  IF_ID_Rs2;
  logic [31:0] fetch_count;

  int checks = 0;
  int errors = 0;

  always #5 clk = ~clk;

  if_id_stage dut (
    .clk          (clk),
    .rst          (rst),
    .stall        (stall),
    .branch_taken (branch_taken),
    .branch_target(branch_target),
    .imem_addr    (imem_addr),
    .imem_rdata   (imem_rdata),
    .imem_ready   (imem_ready),
    .IF_ID_pc     (IF_ID_pc),
    .IF_ID_instr  (IF_ID_instr),
    .IF_ID_valid  (IF_ID_valid),
    .IF_ID_Rs1    (IF_ID_Rs1),
    .IF_ID_Rs2    (IF_ID_Rs2),
    .fetch_count  (fetch_count)
  );

  typedef struct {
    logic        stall;
    logic        br;
    logic [31:0] tgt;
    logic        rdy;
    logic [31:0] rdata;
    logic [31:0] e_addr;
    logic [31:0] e_pc;
    logic [31:0] e_instr;
    logic        e_vld;
    logic [4:0]  e_rs1;
    logic [4:0]  e_rs2;
    logic [31:0] e_cnt;
  } vec_t;

  localparam int NVEC = 15;
  vec_t vecs[NVEC];

  function automatic vec_t mk(logic st, logic br, logic [31:0] tgt, logic rdy, logic [31:0] rd,
                              logic [31:0] ea, logic [31:0] ep, logic [31:0] ei, logic ev,
                              logic [4:0] e1, logic [4:0] e2, logic [31:0] ec);
    vec_t v;
    v.stall = st; v.br = br; v.tgt = tgt; v.rdy = rdy; v.rdata = rd;
    v.e_addr = ea; v.e_pc = ep; v.e_instr = ei; v.e_vld = ev;
    v.e_rs1 = e1; v.e_rs2 = e2; v.e_cnt = ec;
    return v;
  endfunction

  task automatic chk(string name, int idx, logic [31:0] got, logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s step %0d: got %h expected %h", name, idx, got, exp);
    end
  endtask

  task automatic chk_all(int idx, logic [31:0] ea, logic [31:0] ep, logic [31:0] ei, logic ev,
                         logic [4:0] e1, logic [4:0] e2, logic [31:0] ec);
    chk("imem_addr",   idx, imem_addr, ea);
    chk("IF_ID_pc",    idx, IF_ID_pc, ep);
    chk("IF_ID_instr", idx, IF_ID_instr, ei);
    chk("IF_ID_valid", idx, {31'd0, IF_ID_valid}, {31'd0, ev});
    chk("IF_ID_Rs1",   idx, {27'd0, IF_ID_Rs1}, {27'd0, e1});
    chk("IF_ID_Rs2",   idx, {27'd0, IF_ID_Rs2}, {27'd0, e2});
    chk("fetch_count", idx, fetch_count, ec);
  endtask

  localparam logic [31:0] NOP = 32'h0000_0013;
  localparam logic [31:0] I_A = 32'h00A0_0093;  // rs1=0  rs2 field=10
  localparam logic [31:0] I_B = 32'h0020_8133;  // rs1=1  rs2=2
  localparam logic [31:0] I_C = 32'h0031_00B3;  // rs1=2  rs2=3

  initial begin
    //            st  br  tgt           rdy rdata          addr          IF_ID_pc      instr vld rs1 rs2 cnt
    vecs[0]  = mk(0, 0, 32'h0,        1, I_A,          32'h4,        32'h0,        I_A, 1, 0, 10, 1);
    vecs[1]  = mk(0, 0, 32'h0,        1, I_B,          32'h8,        32'h4,        I_B, 1, 1, 2,  2);
    vecs[2]  = mk(1, 0, 32'h0,        1, 32'hDEADBEEF, 32'h8,        32'h4,        I_B, 1, 1, 2,  2);
    vecs[3]  = mk(1, 0, 32'h0,        1, 32'hDEADBEEF, 32'h8,        32'h4,        I_B, 1, 1, 2,  2);
    vecs[4]  = mk(0, 0, 32'h0,        1, I_C,          32'hC,        32'h8,        I_C, 1, 2, 3,  3);
    vecs[5]  = mk(0, 0, 32'h0,        0, 32'hDEADBEEF, 32'hC,        32'h8,        NOP, 0, 0, 0,  3);
    vecs[6]  = mk(0, 0, 32'h0,        0, 32'hDEADBEEF, 32'hC,        32'h8,        NOP, 0, 0, 0,  3);
    vecs[7]  = mk(0, 0, 32'h0,        0, 32'hDEADBEEF, 32'hC,        32'h8,        NOP, 0, 0, 0,  3);
    vecs[8]  = mk(0, 0, 32'h0,        1, I_A,          32'h10,       32'hC,        I_A, 1, 0, 10, 4);
    vecs[9]  = mk(0, 0, 32'h0,        1, I_C,          32'h14,       32'h10,       I_C, 1, 2, 3,  5);
    vecs[10] = mk(1, 1, 32'h103,      1, I_A,          32'h100,      32'h10,       NOP, 0, 0, 0,  5);
    vecs[11] = mk(0, 0, 32'h0,        1, I_B,          32'h104,      32'h100,      I_B, 1, 1, 2,  6);
    vecs[12] = mk(0, 1, 32'hFFFFFFFF, 0, 32'hDEADBEEF, 32'hFFFFFFFC, 32'h100,      NOP, 0, 0, 0,  6);
    vecs[13] = mk(0, 0, 32'h0,        1, I_A,          32'h0,        32'hFFFFFFFC, I_A, 1, 0, 10, 7);
    vecs[14] = mk(0, 1, 32'h14,       0, 32'hDEADBEEF, 32'h14,       32'hFFFFFFFC, NOP, 0, 0, 0,  7);

    rst = 1'b1; stall = 1'b0; branch_taken = 1'b0; branch_target = '0;
    imem_rdata = I_A; imem_ready = 1'b1;
    repeat (3) @(posedge clk);
    #1;
    chk_all(-1, 32'h0, 32'h0, NOP, 0, 0, 0, 0);

    @(negedge clk);
    rst = 1'b0;
    for (int i = 0; i < NVEC; i++) begin
      stall         = vecs[i].stall;
      branch_taken  = vecs[i].br;
      branch_target = vecs[i].tgt;
      imem_ready    = vecs[i].rdy;
      imem_rdata    = vecs[i].rdata;
      @(posedge clk);
      #1;
      chk_all(i, vecs[i].e_addr, vecs[i].e_pc, vecs[i].e_instr, vecs[i].e_vld,
              vecs[i].e_rs1, vecs[i].e_rs2, vecs[i].e_cnt);
      @(negedge clk);
    end

    // Stall at PC=20 with a real word in IF/ID, then hit reset between edges.
    stall = 1'b0; branch_taken = 1'b0; imem_ready = 1'b1; imem_rdata = I_C;
    @(posedge clk);
    #1;
    chk_all(100, 32'h18, 32'h14, I_C, 1, 2, 3, 8);
    @(negedge clk);
    stall = 1'b1; imem_rdata = I_B;
    @(posedge clk);
    #1;
    chk_all(101, 32'h18, 32'h14, I_C, 1, 2, 3, 8);
    #1;
    rst = 1'b1;
    #1;
    chk_all(102, 32'h0, 32'h0, NOP, 0, 0, 0, 0);

    @(negedge clk);
    rst = 1'b0; stall = 1'b0; imem_ready = 1'b1; imem_rdata = I_B;
    @(posedge clk);
    #1;
    chk_all(103, 32'h4, 32'h0, I_B, 1, 1, 2, 1);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
